ps2_key_tracker: RTL
====================

// Module: ps2_key_tracker
// PURPOSE
//  Receives raw PS/2 keyboard frames and decodes make/break/extended scan-code sequences.
//  Produces per-event pulses and a held "key is pressed" level for one selected key.
//  Sits directly upstream of the random-number latch: key_pressed drives its rise input.
//  The same event outputs serve the game-control logic in the keyboard subsystem.
// PARAMETERS
//  KEY_CODE        9'h029  tracked key as {ext,scan}; default is Space
//  TIMEOUT_CYCLES  50000   clk cycles with no ps2_clk falling edge before a partial frame is aborted
// PORTS
//  clk          in   1  system clock
//  resetN       in   1  reset, asynchronous, active-low
//  ps2_clk      in   1  raw PS/2 clock pin, asynchronous to clk
//  ps2_data     in   1  raw PS/2 data pin, asynchronous to clk
//  key_code     out  9  {ext,scan} of the last decoded event; held until the next event
//  make         out  1  1-cycle pulse: key pressed (including typematic repeats)
//  brk          out  1  1-cycle pulse: key released
//  key_pressed  out  1  level: KEY_CODE currently held down
//  frame_err    out  1  1-cycle pulse: bad start/parity/stop bit or timeout
// BEHAVIOUR
//  Reset: all outputs 0, key_code 9'h000, FSM IDLE, ext/brk flags 0, timeout counter 0.
//  Input sync: ps2_clk and ps2_data each pass through 2 flops.
//   fall = (prev synced clk == 1) && (synced clk == 0); data is sampled only on cycles where fall = 1.
//  Frame: start 0, 8 data bits LSB first, odd parity, stop 1.
//  FSM states and transitions (each step on a fall cycle unless noted):
//   IDLE   -> DATA when data == 0 (start bit); data == 1 stays IDLE with no error.
//   DATA   -> shift bits, bit counter 0..7; after the 8th bit -> PARITY.
//   PARITY -> capture the parity bit -> STOP.
//   STOP   -> check the frame -> IDLE.
//    Good frame: parity OK ((^byte ^ p) == 1) and stop == 1.
//    Bad frame: frame_err pulse, byte discarded, ext/brk flags cleared.
//  Timeout: in any non-IDLE state, count clk cycles since the last fall.
//   Counter reset to 0 on each fall.
//   When the count reaches TIMEOUT_CYCLES: -> IDLE, frame_err pulse, flags cleared, partial byte dropped.
//  Byte decode on a good frame:
//   8'hE0 -> set ext flag; no output.
//   8'hF0 -> set brk flag; no output.
//   Flags are independent, so E0 F0 xx and F0 E0 xx both give an extended break.
//   Any other byte -> key_code <= {ext,byte}; pulse make if brk == 0, else pulse brk; clear both flags.
//  Latency: key_code updates and make/brk/frame_err pulse in the clk cycle after the stop-bit fall cycle.
//   All of them are registered and exactly 1 cycle wide.
//  key_pressed: set on a make whose {ext,byte} == KEY_CODE; cleared on a brk whose {ext,byte} == KEY_CODE.
//   Updates in the same cycle as the pulse.
//   Repeated makes keep it at 1 and produce no new 0->1 edge.
//   Other keys and frame errors leave it unchanged.
//  Reset mid-frame: immediate return to reset values; the next complete frame decodes normally.
// TESTING
//  1. Frame 8'h29 -> one make pulse, key_code 9'h029, key_pressed 0->1, brk = frame_err = 0.
//  2. After (1), frames F0,29 -> brk pulse only after the 2nd frame, key_code 9'h029, key_pressed 1->0.
//  3. E0,75 then E0,F0,75 -> make then brk with key_code 9'h175; key_pressed stays 0 throughout.
//  4. Frame 8'h29 with wrong parity, then one with stop = 0 -> two frame_err pulses, no make, key_pressed unchanged.
//  5. Stop ps2_clk after 4 data bits, wait TIMEOUT_CYCLES+5 -> one frame_err pulse.
//     Then good frame 8'h1C -> make with key_code 9'h01C.
//  6. Three repeated 8'h29 frames -> three make pulses, key_pressed rises once.
//     Assert resetN mid-frame -> outputs 0; a following good frame decodes correctly.

Source files
------------

// File: rtl/ps2_key_tracker_if.sv
// Bundles the raw PS/2 pins with the decoded key events.
// The master drives the pins; the tracker is the slave and returns the events.
interface ps2_key_tracker_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic [8:0] key_code;
   logic       make;
   logic       brk;
   logic       key_pressed;
   logic       frame_err;

   modport master (
      output ps2_clk, ps2_data,
      input  key_code, make, brk, key_pressed, frame_err
   );

   modport slave (
      input  ps2_clk, ps2_data,
      output key_code, make, brk, key_pressed, frame_err
   );
endinterface

// File: rtl/ps2_key_tracker.sv
// PS/2 frame receiver and make/break/extended decoder.
// Also holds a pressed level for one selected key.
module ps2_key_tracker #(
   parameter logic [8:0] KEY_CODE       = 9'h029,
   parameter int         TIMEOUT_CYCLES = 50000
) (
   input logic             clk,
   input logic             resetN,
   ps2_key_tracker_if.slave bus
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   state_t             state, next_state;
   logic [2:0]         clk_s;
   logic [1:0]         data_s;
   logic               fall;
   logic               data_bit;
   logic [2:0]         bit_cnt;
   logic [7:0]         shift_reg;
   logic               par_bit;
   logic [CNT_W-1:0]   to_cnt;
   logic               timeout;
   logic               frame_done;
   logic               frame_good;
   logic               ext_flag;
   logic               brk_flag;
   logic [8:0]         code_r;
   logic               make_r;
   logic               brk_r;
   logic               pressed_r;
   logic               err_r;

   // Sync flops idle high so a released line never looks like a falling edge.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         clk_s  <= 3'b111;
         data_s <= 2'b11;
      end else begin
         clk_s  <= {clk_s[1:0], bus.ps2_clk};
         data_s <= {data_s[0], bus.ps2_data};
      end
   end

   assign fall     = clk_s[2] & ~clk_s[1];
   assign data_bit = data_s[1];

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) state <= IDLE;
      else         state <= next_state;
   end

   always_comb begin
      next_state = state;
      frame_done = 1'b0;
      timeout    = (state != IDLE) && !fall && (to_cnt == CNT_W'(TIMEOUT_CYCLES));
      case (state)
         IDLE:   if (fall && !data_bit) next_state = DATA;
         DATA:   if (fall && bit_cnt == 3'd7) next_state = PARITY;
         PARITY: if (fall) next_state = STOP;
         STOP: begin
            if (fall) begin
               next_state = IDLE;
               frame_done = 1'b1;
            end
         end
         default: next_state = IDLE;
      endcase
      if (timeout) next_state = IDLE;
   end

   assign frame_good = frame_done && data_bit && ((^shift_reg ^ par_bit) == 1'b1);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         to_cnt    <= '0;
         bit_cnt   <= 3'd0;
         shift_reg <= 8'h00;
         par_bit   <= 1'b0;
      end else begin
         if (state == IDLE || fall || timeout) to_cnt <= '0;
         else                                  to_cnt <= to_cnt + 1'b1;
         if (state == IDLE) begin
            bit_cnt <= 3'd0;
         end else if (state == DATA && fall) begin
            shift_reg <= {data_bit, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
         end
         if (state == PARITY && fall) par_bit <= data_bit;
      end
   end

   // E0/F0 prefixes only arm flags; any other good byte emits an event and clears them.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         ext_flag  <= 1'b0;
         brk_flag  <= 1'b0;
         code_r    <= 9'h000;
         make_r    <= 1'b0;
         brk_r     <= 1'b0;
         pressed_r <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         make_r <= 1'b0;
         brk_r  <= 1'b0;
         err_r  <= 1'b0;
         if (timeout || (frame_done && !frame_good)) begin
            err_r    <= 1'b1;
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
         end else if (frame_done) begin
            if (shift_reg == 8'hE0) begin
               ext_flag <= 1'b1;
            end else if (shift_reg == 8'hF0) begin
               brk_flag <= 1'b1;
            end else begin
               code_r   <= {ext_flag, shift_reg};
               ext_flag <= 1'b0;
               brk_flag <= 1'b0;
               if (brk_flag) begin
                  brk_r <= 1'b1;
                  if ({ext_flag, shift_reg} == KEY_CODE) pressed_r <= 1'b0;
               end else begin
                  make_r <= 1'b1;
                  if ({ext_flag, shift_reg} == KEY_CODE) pressed_r <= 1'b1;
               end
            end
         end
      end
   end

   assign bus.key_code    = code_r;
   assign bus.make        = make_r;
   assign bus.brk         = brk_r;
   assign bus.key_pressed = pressed_r;
   assign bus.frame_err   = err_r;

endmodule
